// File: rtl/shift_unit_seq_if.sv
// Request/response bundle for shift_unit_seq: operand, op and amount in; result, carry and zero flag out.
interface shift_unit_seq_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_op, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_op, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: pass/LSL/LSR/ASR, at most STEP bit positions per clock, valid/ready on both sides.
module shift_unit_seq #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_unit_seq_if.slave       bus,
  output logic [1:0]            state_o
);
  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the result is held unchanged while out_valid waits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] WIDTH_A = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_A  = AMT_W'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;

  logic [AMT_W-1:0] n_clamp;
  logic [AMT_W-1:0] k;
  logic [WIDTH-1:0] sh_data;
  logic             sh_carry;
  logic             in_ready_c;
  logic             out_valid_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= 2'b00;
      rem_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    n_clamp     = (bus.in_amt > WIDTH_A) ? WIDTH_A : bus.in_amt;
    k           = (rem_q > STEP_A) ? STEP_A : rem_q;
    sh_data     = data_q;
    sh_carry    = carry_q;
    state_d     = state_q;
    data_d      = data_q;
    op_d        = op_q;
    rem_d       = rem_q;
    carry_d     = carry_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    // A k-bit step is unrolled as k single-bit steps so carry is the last bit out.
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) begin
        case (op_q)
          2'b01: begin
            sh_carry = sh_data[WIDTH-1];
            sh_data  = {sh_data[WIDTH-2:0], 1'b0};
          end
          2'b10: begin
            sh_carry = sh_data[0];
            sh_data  = {1'b0, sh_data[WIDTH-1:1]};
          end
          2'b11: begin
            sh_carry = sh_data[0];
            sh_data  = {sh_data[WIDTH-1], sh_data[WIDTH-1:1]};
          end
          default: ;
        endcase
      end
    end

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          op_d    = bus.in_op;
          carry_d = 1'b0;
          if (bus.in_op == 2'b00 || n_clamp == '0) begin
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d   = n_clamp;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d  = sh_data;
        carry_d = sh_carry;
        rem_d   = rem_q - k;
        if (rem_q == k) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = data_q;
  assign bus.out_carry = carry_q;
  assign bus.out_zero  = (data_q == '0);
  assign state_o       = state_q;
endmodule

// File: tb/tb_shift_unit_seq.sv
// Drives a STEP=1 and a STEP=4 shift_unit_seq in lockstep and checks both against a shift model.
module tb_shift_unit_seq;
  localparam int W  = 16;
  localparam int AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_op;
  logic [AW-1:0] in_amt;
  logic [1:0]    state_a, state_b;

  shift_unit_seq_if #(.WIDTH(W), .AMT_W(AW)) bus_a ();
  shift_unit_seq_if #(.WIDTH(W), .AMT_W(AW)) bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.in_op     = in_op;
  assign bus_a.in_amt    = in_amt;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.in_op     = in_op;
  assign bus_b.in_amt    = in_amt;
  assign bus_b.out_ready = out_ready;

  shift_unit_seq #(.WIDTH(W), .STEP(1), .AMT_W(AW)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave), .state_o(state_a)
  );
  shift_unit_seq #(.WIDTH(W), .STEP(4), .AMT_W(AW)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave), .state_o(state_b)
  );

  int total = 0;
  int bad   = 0;
  int steps [2] = '{1, 4};

  // observations of the last run_op, index 0 = STEP 1, 1 = STEP 4
  int           obs_lat  [2];
  logic [W-1:0] obs_d    [2];
  logic         obs_c    [2];
  logic         obs_z    [2];
  logic         obs_idle [2];

  // reference model: plain integer shifts on a clamped distance
  function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] b,
                                    input logic [AW-1:0] amt,
                                    output logic [W-1:0] res, output logic c);
    int n, full, s;
    n = (int'(amt) > W) ? W : int'(amt);
    res = b;
    c = 1'b0;
    if (op != 2'b00 && n != 0) begin
      case (op)
        2'b01: begin
          full = int'(b) << n;
          res = full[W-1:0];
          c = full[W];
        end
        2'b10: begin
          full = int'(b) >> n;
          res = full[W-1:0];
          full = (int'(b) >> (n - 1)) & 1;
          c = full[0];
        end
        default: begin
          s = int'($signed(b));
          full = s >>> n;
          res = full[W-1:0];
          full = (s >>> (n - 1)) & 1;
          c = full[0];
        end
      endcase
    end
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input logic [AW-1:0] amt, input int step);
    int n;
    n = (int'(amt) > W) ? W : int'(amt);
    if (op == 2'b00 || n == 0) return 1;
    return 1 + (n + step - 1) / step;
  endfunction

  // driver: issue one request to both units, record latency/result, then hand off
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] data, input logic [AW-1:0] amt);
    int g;
    g = 0;
    while (!(bus_a.in_ready && bus_b.in_ready) && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      total++;
      bad++;
      $display("FAIL idle_wait: in_ready a=%b b=%b, required 1", bus_a.in_ready, bus_b.in_ready);
    end
    in_valid  = 1'b1;
    in_op     = op;
    in_data   = data;
    in_amt    = amt;
    out_ready = 1'b0;
    obs_lat[0] = 0;
    obs_lat[1] = 0;
    for (int e = 1; e <= 40 && (obs_lat[0] == 0 || obs_lat[1] == 0); e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) begin
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_op    = 2'($urandom);
        in_amt   = AW'($urandom);
      end
      if (obs_lat[0] == 0 && bus_a.out_valid) begin
        obs_lat[0] = e;
        obs_d[0] = bus_a.out_data;
        obs_c[0] = bus_a.out_carry;
        obs_z[0] = bus_a.out_zero;
      end
      if (obs_lat[1] == 0 && bus_b.out_valid) begin
        obs_lat[1] = e;
        obs_d[1] = bus_b.out_data;
        obs_c[1] = bus_b.out_carry;
        obs_z[1] = bus_b.out_zero;
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    obs_idle[0] = bus_a.in_ready && !bus_a.out_valid;
    obs_idle[1] = bus_b.in_ready && !bus_b.out_valid;
  endtask

  task automatic test_reset();
    total++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'h0 ||
        bus_a.out_zero !== 1'b1 || bus_b.in_ready !== 1'b1 || bus_b.out_data !== 16'h0) begin
      bad++;
      $display("FAIL reset_initial: a rdy=%b vld=%b d=%h z=%b b rdy=%b d=%h, required 1 0 0000 1",
               bus_a.in_ready, bus_a.out_valid, bus_a.out_data, bus_a.out_zero,
               bus_b.in_ready, bus_b.out_data);
    end
    in_valid = 1'b1; in_op = 2'b01; in_data = 16'h00F0; in_amt = 5'd5;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++;
    if (state_a !== 2'd1 || state_b !== 2'd1) begin
      bad++;
      $display("FAIL reset_pre_state: a=%0d b=%0d, required 1 (SHIFT)", state_a, state_b);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'h0 ||
        bus_a.out_carry !== 1'b0 || bus_a.out_zero !== 1'b1 || state_a !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_shift_a: rdy=%b vld=%b d=%h c=%b z=%b st=%0d, required 1 0 0000 0 1 0",
               bus_a.in_ready, bus_a.out_valid, bus_a.out_data, bus_a.out_carry, bus_a.out_zero, state_a);
    end
    total++;
    if (bus_b.in_ready !== 1'b1 || bus_b.out_valid !== 1'b0 || bus_b.out_data !== 16'h0 ||
        bus_b.out_carry !== 1'b0 || bus_b.out_zero !== 1'b1 || state_b !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_shift_b: rdy=%b vld=%b d=%h c=%b z=%b st=%0d, required 1 0 0000 0 1 0",
               bus_b.in_ready, bus_b.out_valid, bus_b.out_data, bus_b.out_carry, bus_b.out_zero, state_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); @(negedge clk);
    total++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 ||
        bus_b.in_ready !== 1'b1 || bus_b.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: a rdy=%b vld=%b b rdy=%b vld=%b, required 1 0",
               bus_a.in_ready, bus_a.out_valid, bus_b.in_ready, bus_b.out_valid);
    end
  endtask

  // directed cases with hand-derived results
  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  data;
    logic [AW-1:0] amt;
    logic [W-1:0]  exp_d;
    logic          exp_c;
  } vec_t;

  task automatic test_directed();
    vec_t v [7];
    int lat;
    v[0] = '{2'b10, 16'h8001, 5'd3,  16'h1000, 1'b0};
    v[1] = '{2'b11, 16'h8F00, 5'd10, 16'hFFE3, 1'b1};
    v[2] = '{2'b01, 16'hFFFF, 5'd31, 16'h0000, 1'b1};
    v[3] = '{2'b00, 16'h1234, 5'd7,  16'h1234, 1'b0};
    v[4] = '{2'b01, 16'h0001, 5'd0,  16'h0001, 1'b0};
    v[5] = '{2'b11, 16'h7FFF, 5'd16, 16'h0000, 1'b0};
    v[6] = '{2'b10, 16'h8000, 5'd20, 16'h0000, 1'b1};
    for (int t = 0; t < 7; t++) begin
      run_op(v[t].op, v[t].data, v[t].amt);
      for (int u = 0; u < 2; u++) begin
        lat = ref_latency(v[t].op, v[t].amt, steps[u]);
        total++;
        if (obs_lat[u] != lat || obs_d[u] !== v[t].exp_d || obs_c[u] !== v[t].exp_c ||
            obs_z[u] !== (v[t].exp_d == 16'h0) || obs_idle[u] !== 1'b1) begin
          bad++;
          $display("FAIL directed_%0d_step%0d: lat=%0d d=%h c=%b z=%b idle=%b, required lat=%0d d=%h c=%b z=%b idle=1",
                   t, steps[u], obs_lat[u], obs_d[u], obs_c[u], obs_z[u], obs_idle[u],
                   lat, v[t].exp_d, v[t].exp_c, (v[t].exp_d == 16'h0));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]    op;
    logic [W-1:0]  data, exp_d;
    logic [AW-1:0] amt;
    logic          exp_c;
    int            lat;
    for (int t = 0; t < 40; t++) begin
      op   = 2'($urandom_range(0, 3));
      data = (t % 5 == 0) ? 16'h0 : W'($urandom);
      amt  = AW'($urandom_range(0, 31));
      ref_model(op, data, amt, exp_d, exp_c);
      run_op(op, data, amt);
      for (int u = 0; u < 2; u++) begin
        lat = ref_latency(op, amt, steps[u]);
        total++;
        if (obs_lat[u] != lat || obs_d[u] !== exp_d || obs_c[u] !== exp_c ||
            obs_z[u] !== (exp_d == 16'h0) || obs_idle[u] !== 1'b1) begin
          bad++;
          $display("FAIL random_%0d_step%0d op=%0d b=%h amt=%0d: lat=%0d d=%h c=%b z=%b idle=%b, required lat=%0d d=%h c=%b z=%b",
                   t, steps[u], op, data, amt, obs_lat[u], obs_d[u], obs_c[u], obs_z[u], obs_idle[u],
                   lat, exp_d, exp_c, (exp_d == 16'h0));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int g;
    in_valid = 1'b1; in_op = 2'b01; in_data = 16'h0003; in_amt = 5'd1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    // second request waits while the first result is held
    in_valid = 1'b1; in_op = 2'b01; in_data = 16'h0005; in_amt = 5'd2;
    for (int cyc = 0; cyc < 6; cyc++) begin
      total++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'h0006 || bus_a.in_ready !== 1'b0 ||
          bus_b.out_valid !== 1'b1 || bus_b.out_data !== 16'h0006 || bus_b.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: a vld=%b d=%h rdy=%b b vld=%b d=%h rdy=%b, required 1 0006 0",
                 cyc, bus_a.out_valid, bus_a.out_data, bus_a.in_ready,
                 bus_b.out_valid, bus_b.out_data, bus_b.in_ready);
      end
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (bus_a.in_ready !== 1'b1 || bus_a.out_valid !== 1'b0 || bus_a.out_data !== 16'h0006 ||
        bus_b.in_ready !== 1'b1 || bus_b.out_valid !== 1'b0 || bus_b.out_data !== 16'h0006) begin
      bad++;
      $display("FAIL no_bypass: a rdy=%b vld=%b d=%h b rdy=%b vld=%b d=%h, required 1 0 0006",
               bus_a.in_ready, bus_a.out_valid, bus_a.out_data,
               bus_b.in_ready, bus_b.out_valid, bus_b.out_data);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (bus_a.in_ready !== 1'b0 || bus_b.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL accept_after_handoff: in_ready a=%b b=%b, required 0", bus_a.in_ready, bus_b.in_ready);
    end
    g = 0;
    while (!(bus_a.out_valid && bus_b.out_valid) && g < 20) begin
      @(posedge clk); @(negedge clk);
      g++;
    end
    total++;
    if (bus_a.out_valid !== 1'b1 || bus_a.out_data !== 16'h0014 ||
        bus_b.out_valid !== 1'b1 || bus_b.out_data !== 16'h0014) begin
      bad++;
      $display("FAIL second_result: a vld=%b d=%h b vld=%b d=%h, required 1 0014",
               bus_a.out_valid, bus_a.out_data, bus_b.out_valid, bus_b.out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_op = 2'b00; in_amt = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
